// File: rtl/aes_pkg.sv
// Shared AES types, FSM encoding and GF(2^8) helpers for the iterative encryption core.
package aes_pkg;

    typedef logic [127:0] state_t;

    // FSM encoding
    typedef logic [1:0] fsm_t;
    localparam fsm_t ST_IDLE  = 2'd0;
    localparam fsm_t ST_KEXP  = 2'd1;
    localparam fsm_t ST_ROUND = 2'd2;
    localparam fsm_t ST_DONE  = 2'd3;

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        p  = 8'h00;
        aa = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ aa;
            aa = xtime(aa);
        end
        return p;
    endfunction

    // S-box as multiplicative inverse (x^254, so 0 maps to 0) followed by the affine map
    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [7:0] sq;
        logic [7:0] inv;
        sq  = x;
        inv = 8'h01;
        for (int i = 1; i < 8; i++) begin
            sq  = gf_mul(sq, sq);
            inv = gf_mul(inv, sq);
        end
        return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
               ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
    endfunction

    function automatic logic [31:0] rot_word(input logic [31:0] w);
        return {w[23:0], w[31:24]};
    endfunction

    function automatic logic [7:0] rcon(input logic [3:0] idx);
        case (idx)
            4'd1:    return 8'h01;
            4'd2:    return 8'h02;
            4'd3:    return 8'h04;
            4'd4:    return 8'h08;
            4'd5:    return 8'h10;
            4'd6:    return 8'h20;
            4'd7:    return 8'h40;
            4'd8:    return 8'h80;
            4'd9:    return 8'h1b;
            4'd10:   return 8'h36;
            default: return 8'h00;
        endcase
    endfunction

    function automatic bit params_legal(input int key_len, input int nr, input int nk);
        return (key_len == 128 && nr == 10 && nk == 4) ||
               (key_len == 192 && nr == 12 && nk == 6) ||
               (key_len == 256 && nr == 14 && nk == 8);
    endfunction

endpackage

// File: rtl/aes_round.sv
// One combinational AES round: SubBytes, ShiftRows, optional MixColumns, AddRoundKey.
module aes_round
    import aes_pkg::*;
(
    input  state_t state,
    input  state_t round_key,
    input  logic   last,
    output state_t next_state
);

    logic [7:0] sb [16];
    logic [7:0] sr [16];
    logic [7:0] mc [16];

    // Byte k sits at row k%4, column k/4; byte 0 is the MSB
    always_comb begin
        for (int k = 0; k < 16; k++) begin
            sb[k] = sbox(state[127-8*k -: 8]);
        end
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                sr[4*c+r] = sb[4*((c+r)%4)+r];
            end
        end
        for (int c = 0; c < 4; c++) begin
            mc[4*c]   = xtime(sr[4*c]) ^ xtime(sr[4*c+1]) ^ sr[4*c+1] ^ sr[4*c+2] ^ sr[4*c+3];
            mc[4*c+1] = sr[4*c] ^ xtime(sr[4*c+1]) ^ xtime(sr[4*c+2]) ^ sr[4*c+2] ^ sr[4*c+3];
            mc[4*c+2] = sr[4*c] ^ sr[4*c+1] ^ xtime(sr[4*c+2]) ^ xtime(sr[4*c+3]) ^ sr[4*c+3];
            mc[4*c+3] = xtime(sr[4*c]) ^ sr[4*c] ^ sr[4*c+1] ^ sr[4*c+2] ^ xtime(sr[4*c+3]);
        end
        for (int k = 0; k < 16; k++) begin
            next_state[127-8*k -: 8] = (last ? sr[k] : mc[k]) ^ round_key[127-8*k -: 8];
        end
    end

endmodule

// File: rtl/aes_encrypt_iter.sv
// Iterative AES encryption core: one round per clock, on-chip key expansion with a key cache.
module aes_encrypt_iter
    import aes_pkg::*;
#(
    parameter int KEY_LEN = 128,
    parameter int NR      = 10,
    parameter int NK      = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [127:0]       in_data,
    input  logic [KEY_LEN-1:0] in_key,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [127:0]       out_data,
    output logic               busy
);

    localparam int NW = 4 * (NR + 1);
    localparam int CW = $clog2(NW);

    if (!params_legal(KEY_LEN, NR, NK)) begin : g_bad_params
        $error("aes_encrypt_iter: illegal KEY_LEN/NR/NK triple");
    end

    fsm_t               state_q, state_d;
    state_t             blk_q, blk_d;
    state_t             out_data_q, out_data_d;
    state_t             round_key, round_out;
    logic [3:0]         rnd_q, rnd_d;
    logic [CW-1:0]      widx_q, widx_d;
    logic [CW-1:0]      prev_idx, back_idx, rk_idx;
    logic [KEY_LEN-1:0] key_q, key_d;
    logic               cache_valid_q, cache_valid_d;
    logic               out_valid_q, out_valid_d;
    logic [31:0]        w_q [NW];
    logic [31:0]        w_d [NW];
    logic [31:0]        prev_word, temp_word, new_word;
    logic               cache_hit, last_round;

    // Next key-schedule word w[widx] from w[widx-1] and w[widx-NK]
    always_comb begin
        prev_idx  = widx_q - CW'(1);
        back_idx  = widx_q - CW'(NK);
        prev_word = w_q[prev_idx];
        if (int'(widx_q) % NK == 0) begin
            temp_word = sub_word(rot_word(prev_word)) ^ {rcon(4'(int'(widx_q) / NK)), 24'h0};
        end else if (NK == 8 && int'(widx_q) % NK == 4) begin
            temp_word = sub_word(prev_word);
        end else begin
            temp_word = prev_word;
        end
        new_word = w_q[back_idx] ^ temp_word;
    end

    // Round key selection w[4r..4r+3]
    always_comb begin
        rk_idx     = CW'({rnd_q, 2'b00});
        round_key  = {w_q[rk_idx], w_q[rk_idx + CW'(1)], w_q[rk_idx + CW'(2)],
                      w_q[rk_idx + CW'(3)]};
        last_round = (rnd_q == 4'(NR));
        cache_hit  = cache_valid_q && (in_key == key_q);
    end

    aes_round u_round (
        .state      (blk_q),
        .round_key  (round_key),
        .last       (last_round),
        .next_state (round_out)
    );

    // FSM and datapath next-state
    always_comb begin
        state_d       = state_q;
        blk_d         = blk_q;
        out_data_d    = out_data_q;
        rnd_d         = rnd_q;
        widx_d        = widx_q;
        key_d         = key_q;
        cache_valid_d = cache_valid_q;
        out_valid_d   = out_valid_q;
        w_d           = w_q;
        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    blk_d = in_data ^ in_key[KEY_LEN-1 -: 128];
                    rnd_d = 4'd1;
                    if (cache_hit) begin
                        state_d = ST_ROUND;
                    end else begin
                        for (int j = 0; j < NK; j++) begin
                            w_d[j] = in_key[KEY_LEN-1-32*j -: 32];
                        end
                        key_d         = in_key;
                        cache_valid_d = 1'b0;
                        widx_d        = CW'(NK);
                        state_d       = ST_KEXP;
                    end
                end
            end
            ST_KEXP: begin
                w_d[widx_q] = new_word;
                widx_d      = widx_q + CW'(1);
                if (widx_q == CW'(NW - 1)) begin
                    cache_valid_d = 1'b1;
                    state_d       = ST_ROUND;
                end
            end
            ST_ROUND: begin
                blk_d = round_out;
                rnd_d = rnd_q + 4'd1;
                if (last_round) begin
                    out_data_d  = round_out;
                    out_valid_d = 1'b1;
                    state_d     = ST_DONE;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Control and data registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            blk_q         <= '0;
            out_data_q    <= '0;
            rnd_q         <= '0;
            widx_q        <= '0;
            key_q         <= '0;
            cache_valid_q <= 1'b0;
            out_valid_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            blk_q         <= blk_d;
            out_data_q    <= out_data_d;
            rnd_q         <= rnd_d;
            widx_q        <= widx_d;
            key_q         <= key_d;
            cache_valid_q <= cache_valid_d;
            out_valid_q   <= out_valid_d;
        end
    end

    // Key schedule storage; contents are only trusted while cache_valid_q is set
    always_ff @(posedge clk) begin
        w_q <= w_d;
    end

    assign in_ready  = (state_q == ST_IDLE);
    assign busy      = (state_q != ST_IDLE);
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;

endmodule

// File: tb/tb_aes_encrypt_iter.sv
// Scoreboard bench for aes_encrypt_iter with one instance per key length.
module tb_aes_encrypt_iter;

    logic             clk = 1'b0;
    logic             rst;
    logic [2:0]       in_valid, in_ready, out_valid, out_ready, busy;
    logic [127:0]     in_data;
    logic [127:0]     key128;
    logic [191:0]     key192;
    logic [255:0]     key256;
    logic [2:0][127:0] out_data;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [127:0] data;
        int           lat;
    } exp_t;
    exp_t exp_q[$];

    localparam logic [255:0] K_FIPS = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};
    localparam logic [255:0] K_SEQ  = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
    localparam logic [127:0] PT_SEQ = 128'h00112233445566778899aabbccddeeff;

    always #5 clk = ~clk;

    aes_encrypt_iter #(.KEY_LEN(128), .NR(10), .NK(4)) u_aes128 (
        .clk(clk), .rst(rst), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
        .in_data(in_data), .in_key(key128), .out_valid(out_valid[0]),
        .out_ready(out_ready[0]), .out_data(out_data[0]), .busy(busy[0])
    );
    aes_encrypt_iter #(.KEY_LEN(192), .NR(12), .NK(6)) u_aes192 (
        .clk(clk), .rst(rst), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
        .in_data(in_data), .in_key(key192), .out_valid(out_valid[1]),
        .out_ready(out_ready[1]), .out_data(out_data[1]), .busy(busy[1])
    );
    aes_encrypt_iter #(.KEY_LEN(256), .NR(14), .NK(8)) u_aes256 (
        .clk(clk), .rst(rst), .in_valid(in_valid[2]), .in_ready(in_ready[2]),
        .in_data(in_data), .in_key(key256), .out_valid(out_valid[2]),
        .out_ready(out_ready[2]), .out_data(out_data[2]), .busy(busy[2])
    );

    // Present one block to instance c; key is left-aligned. Returns #1 after the accept edge.
    task automatic send(input int c, input logic [255:0] key, input logic [127:0] pt,
                        input logic [127:0] exp_ct, input int exp_lat, output bit accepted);
        exp_t e;
        int   n;
        @(negedge clk);
        n = 0;
        while (!in_ready[c] && n < 200) begin
            @(negedge clk);
            n++;
        end
        accepted = in_ready[c];
        if (!accepted) return;
        in_data     = pt;
        key128      = key[255:128];
        key192      = key[255:64];
        key256      = key;
        in_valid[c] = 1'b1;
        @(posedge clk);
        #1;
        in_valid[c] = 1'b0;
        e.data = exp_ct;
        e.lat  = exp_lat;
        exp_q.push_back(e);
    endtask

    // Count edges after the accept edge until out_valid is seen (bounded)
    task automatic wait_out(input int c, input int bound, output logic [127:0] data,
                            output int lat, output bit seen);
        int n;
        n = 0;
        while (!out_valid[c] && n < bound) begin
            @(posedge clk);
            #1;
            n++;
        end
        seen = out_valid[c];
        data = out_data[c];
        lat  = n;
    endtask

    task automatic pulse_reset;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset;
        rst       = 1'b1;
        in_valid  = '0;
        out_ready = '1;
        in_data   = '0;
        key128    = '0;
        key192    = '0;
        key256    = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        for (int c = 0; c < 3; c++) begin
            checks++;
            if (in_ready[c] !== 1'b1) begin
                errors++;
                $display("FAIL reset_in_ready[%0d]: got %b expected 1", c, in_ready[c]);
            end
            checks++;
            if (out_valid[c] !== 1'b0) begin
                errors++;
                $display("FAIL reset_out_valid[%0d]: got %b expected 0", c, out_valid[c]);
            end
            checks++;
            if (out_data[c] !== 128'h0) begin
                errors++;
                $display("FAIL reset_out_data[%0d]: got %h expected 0", c, out_data[c]);
            end
            checks++;
            if (busy[c] !== 1'b0) begin
                errors++;
                $display("FAIL reset_busy[%0d]: got %b expected 0", c, busy[c]);
            end
        end
    endtask

    // Miss or hit on one instance, compared against the scoreboard head
    task automatic test_block(input string name, input int c, input logic [255:0] key,
                              input logic [127:0] pt, input logic [127:0] ct, input int lat_exp);
        bit           ok, seen;
        logic [127:0] d;
        int           lat;
        exp_t         e;
        send(c, key, pt, ct, lat_exp, ok);
        checks++;
        if (ok !== 1'b1) begin
            errors++;
            $display("FAIL %s_accept: in_ready stayed low", name);
            return;
        end
        wait_out(c, 200, d, lat, seen);
        e = exp_q.pop_front();
        checks++;
        if (seen !== 1'b1) begin
            errors++;
            $display("FAIL %s_valid: out_valid never rose (waited %0d)", name, lat);
        end
        checks++;
        if (d !== e.data) begin
            errors++;
            $display("FAIL %s_data: got %h expected %h", name, d, e.data);
        end
        checks++;
        if (lat != e.lat) begin
            errors++;
            $display("FAIL %s_latency: got %0d expected %0d", name, lat, e.lat);
        end
        @(posedge clk);
        #1;
        checks++;
        if (out_valid[c] !== 1'b0 || in_ready[c] !== 1'b1) begin
            errors++;
            $display("FAIL %s_handshake: out_valid=%b in_ready=%b expected 0/1", name,
                     out_valid[c], in_ready[c]);
        end
    endtask

    task automatic test_fips128;
        test_block("fips128", 0, K_FIPS, 128'h3243f6a8885a308d313198a2e0370734,
                   128'h3925841d02dc09fbdc118597196a0b32, 50);
    endtask

    task automatic test_back_to_back;
        test_block("b2b_miss", 0, {K_SEQ[255:128], 128'h0}, PT_SEQ,
                   128'h69c4e0d86a7b0430d8cdb78070b4c55a, 50);
        test_block("b2b_hit", 0, {K_SEQ[255:128], 128'h0}, PT_SEQ,
                   128'h69c4e0d86a7b0430d8cdb78070b4c55a, 10);
    endtask

    task automatic test_aes192;
        test_block("aes192", 1, {K_SEQ[255:64], 64'h0}, PT_SEQ,
                   128'hdda97ca4864cdfe06eaf70a0ec0d7191, 58);
    endtask

    task automatic test_aes256;
        test_block("aes256", 2, K_SEQ, PT_SEQ, 128'h8ea2b7ca516745bfeafc49904b496089, 66);
    endtask

    task automatic test_backpressure;
        bit           ok, seen;
        logic [127:0] d;
        int           lat;
        int           bad;
        exp_t         e;
        out_ready[0] = 1'b0;
        send(0, {K_SEQ[255:128], 128'h0}, PT_SEQ, 128'h69c4e0d86a7b0430d8cdb78070b4c55a, 10, ok);
        checks++;
        if (ok !== 1'b1) begin
            errors++;
            $display("FAIL bp_accept: in_ready stayed low");
            out_ready[0] = 1'b1;
            return;
        end
        wait_out(0, 200, d, lat, seen);
        e = exp_q.pop_front();
        checks++;
        if (seen !== 1'b1 || d !== e.data || lat != e.lat) begin
            errors++;
            $display("FAIL bp_result: valid=%b data=%h lat=%0d expected 1 %h %0d", seen, d, lat,
                     e.data, e.lat);
        end
        // A competing block offered while stalled must be ignored
        in_data     = 128'hdeadbeefcafef00d0123456789abcdef;
        in_valid[0] = 1'b1;
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            #1;
            checks++;
            if (out_valid[0] !== 1'b1 || out_data[0] !== e.data || in_ready[0] !== 1'b0) begin
                errors++;
                bad++;
                $display("FAIL bp_stall[%0d]: valid=%b ready=%b data=%h expected 1 0 %h", i,
                         out_valid[0], in_ready[0], out_data[0], e.data);
            end
        end
        in_valid[0]  = 1'b0;
        out_ready[0] = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (out_valid[0] !== 1'b0) begin
            errors++;
            $display("FAIL bp_release: out_valid=%b expected 0", out_valid[0]);
        end
        for (int i = 0; i < 15; i++) begin
            @(posedge clk);
            #1;
            checks++;
            if (out_valid[0] !== 1'b0 || busy[0] !== 1'b0) begin
                errors++;
                $display("FAIL bp_ghost[%0d]: out_valid=%b busy=%b expected 0 0", i,
                         out_valid[0], busy[0]);
            end
        end
    endtask

    // Abort a block with rst after c_cycles, confirm silence, then resubmit as a miss
    task automatic test_abort(input string name, input int c, input logic [255:0] key,
                              input logic [127:0] pt, input logic [127:0] ct, input int abort_lat,
                              input int miss_lat, input int c_cycles);
        bit           ok, seen;
        logic [127:0] d;
        int           lat;
        send(c, key, pt, ct, abort_lat, ok);
        checks++;
        if (ok !== 1'b1) begin
            errors++;
            $display("FAIL %s_accept: in_ready stayed low", name);
            return;
        end
        repeat (c_cycles) @(posedge clk);
        pulse_reset();
        exp_q.delete();
        checks++;
        if (busy[c] !== 1'b0 || out_valid[c] !== 1'b0) begin
            errors++;
            $display("FAIL %s_after_rst: busy=%b out_valid=%b expected 0 0", name, busy[c],
                     out_valid[c]);
        end
        wait_out(c, miss_lat + 20, d, lat, seen);
        checks++;
        if (seen !== 1'b0) begin
            errors++;
            $display("FAIL %s_no_output: out_valid=%b after %0d cycles expected 0", name, seen,
                     lat);
        end
        test_block({name, "_resubmit"}, c, key, pt, ct, miss_lat);
    endtask

    task automatic test_reset_midkexp;
        test_abort("rst_kexp", 0, K_FIPS, 128'h3243f6a8885a308d313198a2e0370734,
                   128'h3925841d02dc09fbdc118597196a0b32, 50, 50, 10);
    endtask

    task automatic test_reset_midround;
        // Fill the cache first, then abort a hit mid-round; the resubmit must miss
        test_block("rst_round_fill", 1, {K_SEQ[255:64], 64'h0}, PT_SEQ,
                   128'hdda97ca4864cdfe06eaf70a0ec0d7191, 58);
        test_abort("rst_round", 1, {K_SEQ[255:64], 64'h0}, PT_SEQ,
                   128'hdda97ca4864cdfe06eaf70a0ec0d7191, 12, 58, 5);
    endtask

    initial begin
        test_reset();
        test_fips128();
        test_back_to_back();
        test_aes192();
        test_aes256();
        test_backpressure();
        test_reset_midkexp();
        test_reset_midround();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
